// File: rtl/pm_pkg.sv
// pm_pkg: shared types and default timing constants for the pacemaker front end and controller.
package pm_pkg;

    typedef enum logic {IDLE, REFRACT} state_t;

    localparam int CLK_HZ      = 12_000_000;
    localparam int TICK_DIV    = CLK_HZ / 1000;
    localparam int FILT_CYCLES = CLK_HZ / 10_000;
    localparam int REFRACT_MS  = 250;
    localparam int RR_W        = 12;

endpackage

// File: rtl/sense_filter.sv
// sense_filter: 2-flop synchroniser plus stability filter; lvl changes only after FILT_CYCLES
// consecutive clocks of a differing synced value, rise flags the cycle after lvl goes high.
module sense_filter #(
    parameter int FILT_CYCLES = pm_pkg::FILT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl,
    output logic rise
);

    localparam int CW = $clog2(FILT_CYCLES + 1);

    logic          s1, s2, lvl_d;
    logic [CW-1:0] cnt;

    assign rise = lvl & ~lvl_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl   <= 1'b0;
            lvl_d <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            lvl_d <= lvl;
            if (s2 == lvl)
                cnt <= '0;
            else if (cnt == CW'(FILT_CYCLES - 1)) begin
                lvl <= ~lvl;
                cnt <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sense_front_end.sv
// sense_front_end: filtered heartbeat sensing with refractory blanking and R-R interval measurement.
module sense_front_end
    import pm_pkg::*;
#(
    parameter int FILT_CYCLES = pm_pkg::FILT_CYCLES,
    parameter int TICK_DIV    = pm_pkg::TICK_DIV,
    parameter int REFRACT_MS  = pm_pkg::REFRACT_MS,
    parameter int RR_W        = pm_pkg::RR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sense_raw,
    input  logic            pace_evt,
    input  logic            enable,
    output logic            sense_pulse,
    output logic            refractory,
    output logic [RR_W-1:0] rr_ms,
    output logic            rr_valid
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(REFRACT_MS + 1);

    state_t          state;
    logic [PW-1:0]   pre;
    logic [CW-1:0]   refract_cnt;
    logic [RR_W-1:0] rr_count, rr_next;
    logic            have_ref, filt_lvl, filt_rise;
    logic            tick, cand, pace, acc, evt;

    sense_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt (
        .clk  (clk),
        .rst  (rst),
        .raw  (sense_raw),
        .lvl  (filt_lvl),
        .rise (filt_rise)
    );

    // rr_next includes the tick landing on this edge so the interval spans whole event-to-event clocks
    always_comb begin
        tick    = pre == PW'(TICK_DIV - 1);
        rr_next = (tick && rr_count != '1) ? rr_count + 1'b1 : rr_count;
        cand    = filt_rise & filt_lvl;
        pace    = enable & pace_evt;
        acc     = enable & cand & (state == IDLE) & ~pace_evt;
        evt     = acc | pace;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pre         <= '0;
            refract_cnt <= '0;
            rr_count    <= '0;
            have_ref    <= 1'b0;
            sense_pulse <= 1'b0;
            refractory  <= 1'b0;
            rr_ms       <= '0;
            rr_valid    <= 1'b0;
        end else begin
            sense_pulse <= acc;
            rr_valid    <= acc & have_ref;
            if (acc && have_ref)
                rr_ms <= rr_next;
            pre      <= (evt || tick) ? '0 : pre + 1'b1;
            rr_count <= evt ? '0 : rr_next;
            if (!enable) begin
                state       <= IDLE;
                refractory  <= 1'b0;
                have_ref    <= 1'b0;
                refract_cnt <= '0;
            end else if (evt) begin
                state       <= REFRACT;
                refractory  <= 1'b1;
                have_ref    <= 1'b1;
                refract_cnt <= CW'(REFRACT_MS);
            end else if (state == REFRACT && tick) begin
                refract_cnt <= refract_cnt - 1'b1;
                if (refract_cnt == CW'(1)) begin
                    state      <= IDLE;
                    refractory <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sense_front_end.sv
// tb_sense_front_end: directed checks of sense_front_end with small timing parameters.
module tb_sense_front_end;

    localparam int FILT = 4, TDIV = 10, RMS = 25, RRW = 12;

    logic           clk = 1'b0, rst = 1'b1, sense_raw = 1'b0, pace_evt = 1'b0, enable = 1'b0;
    logic           sense_pulse, refractory, rr_valid;
    logic [RRW-1:0] rr_ms;

    int ncmp = 0, nerr = 0;
    int cyc = 0, npulse = 0, nvalid = 0, nref = 0, nlvl = 0, pcyc = 0;

    always #5 clk = ~clk;

    sense_front_end #(
        .FILT_CYCLES (FILT),
        .TICK_DIV    (TDIV),
        .REFRACT_MS  (RMS),
        .RR_W        (RRW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sense_raw   (sense_raw),
        .pace_evt    (pace_evt),
        .enable      (enable),
        .sense_pulse (sense_pulse),
        .refractory  (refractory),
        .rr_ms       (rr_ms),
        .rr_valid    (rr_valid)
    );

    // cyc = number of rising edges seen; event counters sampled 1 time unit after each edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (sense_pulse) begin
            npulse++;
            pcyc = cyc;
        end
        if (rr_valid) nvalid++;
        if (refractory) nref++;
        if (dut.filt_lvl) nlvl++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic beat(input int len);
        sense_raw = 1'b1;
        repeat (len) @(negedge clk);
        sense_raw = 1'b0;
    endtask

    initial begin
        int s, t, c, g, p0, v0, r0, l0;
        repeat (3) @(negedge clk);
        chk("rst_pulse", sense_pulse, 0);
        chk("rst_refract", refractory, 0);
        chk("rst_rr_ms", rr_ms, 0);
        chk("rst_rr_valid", rr_valid, 0);
        rst = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // clean pulse: latency, single event, no rr, 250-clock window
        s = cyc;
        beat(50);
        wait_to(s + 300);
        chk("t1_pulses", npulse, 1);
        chk("t1_latency", pcyc - s, 7);
        chk("t1_valid", nvalid, 0);
        chk("t1_refract_len", nref, 250);
        chk("t1_refract_end", refractory, 0);

        // glitch rejection
        p0 = npulse;
        l0 = nlvl;
        repeat (10) begin
            beat(3);
            repeat (4) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("t2_pulses", npulse - p0, 0);
        chk("t2_lvl_cycles", nlvl - l0, 0);

        // R-R measurement
        t = cyc;
        beat(20);
        wait_to(t + 100);
        v0 = nvalid;
        wait_to(t + 800);
        beat(20);
        wait_to(t + 820);
        chk("t3_valid_b", nvalid - v0, 1);
        chk("t3_rr_80", rr_ms, 80);
        wait_to(t + 1200);
        beat(20);
        wait_to(t + 1220);
        chk("t3_valid_c", nvalid - v0, 2);
        chk("t3_rr_40", rr_ms, 40);

        // refractory blanking
        t = cyc + 300;
        p0 = npulse;
        wait_to(t);
        beat(20);
        wait_to(t + 100);
        beat(20);
        wait_to(t + 130);
        chk("t4_blanked", npulse - p0, 1);
        wait_to(t + 300);
        beat(20);
        wait_to(t + 320);
        chk("t4_accepted", npulse - p0, 2);
        chk("t4_rr_30", rr_ms, 30);

        // pace then beat 300 clocks later
        wait_to(t + 600);
        c = cyc;
        pace_evt = 1'b1;
        @(negedge clk);
        pace_evt = 1'b0;
        chk("t5a_refract", refractory, 1);
        v0 = nvalid;
        wait_to(c + 294);
        beat(20);
        wait_to(c + 320);
        chk("t5a_valid", nvalid - v0, 1);
        chk("t5a_rr_30", rr_ms, 30);

        // pace 200 clocks into a window extends it
        wait_to(c + 600);
        t = cyc;
        r0 = nref;
        p0 = npulse;
        beat(20);
        g = t + 7;
        wait_to(g + 199);
        pace_evt = 1'b1;
        @(negedge clk);
        pace_evt = 1'b0;
        wait_to(g + 449);
        chk("t5b_still_on", refractory, 1);
        wait_to(g + 450);
        chk("t5b_off", refractory, 0);
        chk("t5b_len", nref - r0, 450);
        chk("t5b_pulses", npulse - p0, 1);

        // pace coincident with candidate
        wait_to(cyc + 50);
        t = cyc;
        p0 = npulse;
        v0 = nvalid;
        sense_raw = 1'b1;
        wait_to(t + 6);
        pace_evt = 1'b1;
        @(negedge clk);
        pace_evt = 1'b0;
        wait_to(t + 20);
        sense_raw = 1'b0;
        chk("t5c_no_pulse", npulse - p0, 0);
        chk("t5c_no_valid", nvalid - v0, 0);
        chk("t5c_refract", refractory, 1);
        wait_to(t + 256);
        chk("t5c_win_last", refractory, 1);
        wait_to(t + 257);
        chk("t5c_win_end", refractory, 0);

        // enable drop during refractory
        repeat (5) @(negedge clk);
        pace_evt = 1'b1;
        @(negedge clk);
        pace_evt = 1'b0;
        chk("t6a_refract_on", refractory, 1);
        enable = 1'b0;
        @(negedge clk);
        chk("t6a_refract_off", refractory, 0);
        pace_evt = 1'b1;
        @(negedge clk);
        pace_evt = 1'b0;
        @(negedge clk);
        chk("t6a_pace_ignored", refractory, 0);
        enable = 1'b1;
        @(negedge clk);
        t = cyc;
        p0 = npulse;
        v0 = nvalid;
        beat(20);
        wait_to(t + 30);
        chk("t6a_pulse", npulse - p0, 1);
        chk("t6a_no_valid", nvalid - v0, 0);
        chk("t6a_rr_held", rr_ms, 30);

        // async reset mid-window
        chk("t6b_pre_refract", refractory, 1);
        rst = 1'b1;
        #1;
        chk("t6b_pulse", sense_pulse, 0);
        chk("t6b_refract", refractory, 0);
        chk("t6b_rr_ms", rr_ms, 0);
        chk("t6b_rr_valid", rr_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        t = cyc;
        p0 = npulse;
        v0 = nvalid;
        beat(20);
        wait_to(t + 30);
        chk("t6b_pulse_after", npulse - p0, 1);
        chk("t6b_no_valid", nvalid - v0, 0);

        // R-R saturation at 4095
        wait_to(t + 41000);
        beat(20);
        wait_to(t + 41030);
        chk("sat_valid", nvalid - v0, 1);
        chk("sat_rr", rr_ms, 4095);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
